// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
package ps2_pkg;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam int         ENTRY_W   = 9;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
endpackage

// File: rtl/ps2_kbd_fifo_sync_fifo.sv
// Single-clock FIFO with combinational head; drop flags a push refused while full.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard deframer with break/extended prefix handling feeding a CPU-read FIFO.
module ps2_kbd_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output logic        frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic                 clk_s1, clk_s2, clk_prev;
  logic                 dat_s1, dat_s2;
  logic                 fall;
  rx_state_t            state, state_nxt;
  logic [2:0]           bit_cnt;
  logic [7:0]           shift;
  logic                 par;
  logic [TW-1:0]        to_cnt;
  logic                 timeout;
  logic                 brk, ext;
  logic                 frame_good, frame_bad;
  logic                 push, drop;
  logic [ENTRY_W-1:0]   head;

  assign fall    = clk_prev & ~clk_s2;
  assign timeout = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nxt  = state;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!dat_s2) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          if ((^{shift, par}) && dat_s2) frame_good = 1'b1;
          else                           frame_bad  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign frame_err = frame_bad;
  assign push      = frame_good && (shift != PS2_BREAK) && (shift != PS2_EXT) && !brk;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Lines idle high; resetting the synchronizers high avoids a false edge after reset.
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      to_cnt   <= '0;
      brk      <= 1'b0;
      ext      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat;
      dat_s2   <= dat_s1;
      state    <= state_nxt;

      if (fall || state == IDLE) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;

      if (timeout) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (fall) begin
        case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  par <= dat_s2;
          default: ;
        endcase
      end

      if (frame_good) begin
        if (shift == PS2_BREAK)    brk <= 1'b1;
        else if (shift == PS2_EXT) ext <= 1'b1;
        else begin
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end

      if (drop) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rd_en),
    .wdata ({ext, shift}),
    .head  (head),
    .empty (empty),
    .full  (full),
    .drop  (drop)
  );

  assign rd_data = empty ? 32'd0 : {22'd0, 1'b1, head};
endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Scoreboard bench: frames queue expected reads; a monitor checks every CPU read and frame_err pulse.
module tb_ps2_kbd_fifo;
  localparam int DEPTH = 16;
  localparam int TO    = 200;
  localparam int H     = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_dat;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        empty, full, overflow, frame_err;

  int          vectors = 0;
  int          miscompares = 0;
  int          err_cnt = 0;
  logic [31:0] exp_q [$];

  ps2_kbd_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every read cycle pops the scoreboard; an empty scoreboard expects all-zero data.
  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (rd_en && !rst) begin
      if (exp_q.size() == 0) check("read_empty", rd_data, 32'd0);
      else                   check("read_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      tick(H);
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    tick(H);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic read_one();
    tick(1);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tick(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_ferr"}, 32'(frame_err), 32'd0);
    check({tag, "_rdata"}, rd_data, 32'd0);
  endtask

  initial begin
    int e0;
    rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rd_en = 1'b0;
    tick(5);
    check_reset_outputs("rst");
    rst = 1'b0;
    tick(2);

    // Single make code
    send(8'h1C);
    exp_q.push_back(32'h21C);
    @(negedge clk);
    check("one_empty", 32'(empty), 32'd0);
    check("one_head", rd_data, 32'h21C);
    read_one();
    @(negedge clk);
    check("one_drained_empty", 32'(empty), 32'd1);
    check("one_drained_rdata", rd_data, 32'd0);

    // Break sequence is swallowed; extra pop on empty is harmless
    send(8'h1C); exp_q.push_back(32'h21C);
    send(8'hF0); send(8'h1C);
    read_one();
    read_one();
    @(negedge clk);
    check("brk_empty", 32'(empty), 32'd1);

    // Extended make, extended break, then a plain make sees ext cleared
    send(8'hE0); send(8'h75); exp_q.push_back(32'h375);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h1C); exp_q.push_back(32'h21C);
    read_one();
    read_one();
    @(negedge clk);
    check("ext_empty", 32'(empty), 32'd1);

    // Parity and stop errors
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    check("par_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("par_err_empty", 32'(empty), 32'd1);
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check("stop_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("stop_err_empty", 32'(empty), 32'd1);

    // Fill to DEPTH, then one more overflows
    for (int i = 1; i <= DEPTH; i++) begin
      send(8'(i));
      exp_q.push_back(32'h200 | 32'(i));
    end
    @(negedge clk);
    check("fill_full", 32'(full), 32'd1);
    check("fill_no_ovf", 32'(overflow), 32'd0);
    send(8'h11);
    @(negedge clk);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_full", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) read_one();
    read_one();
    @(negedge clk);
    check("ovf_drained_empty", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Partial frame abandoned by timeout
    e0 = err_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 5);
    tick(TO + 50);
    send(8'h1C); exp_q.push_back(32'h21C);
    check("to_no_err", 32'(err_cnt - e0), 32'd0);
    read_one();

    // Reset in the middle of a frame
    send_frame(8'h55, 1'b0, 1'b0, 5);
    rst = 1'b1;
    tick(3);
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick(2);
    send(8'h1C); exp_q.push_back(32'h21C);
    @(negedge clk);
    check("midrst_head", rd_data, 32'h21C);
    read_one();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
